// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sequencer
//  Description : Drives all 32 input vectors {a,b,c,d,e} into a combinational
//                stage and holds each vector for DWELL cycles. At the end of
//                each hold it samples the response f and builds a 32-bit
//                truth table.
//                The optional compare logic is enabled with the macro
//                TRUTH_TABLE_COMPARE_EN. It adds an expected-table input, a
//                mismatch counter and a pass flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
    parameter int DWELL = 5          // cycles each vector is held, 2..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f,
`ifdef TRUTH_TABLE_COMPARE_EN
    input  logic [31:0] expected,
    output logic [5:0]  mismatch_cnt,
    output logic        pass,
`endif
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        busy,
    output logic        done,
    output logic [4:0]  idx,
    output logic [31:0] tt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [7:0] c_last_cnt = 8'(DWELL - 1);
    localparam logic [4:0] c_last_idx = 5'd31;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_idx;
    logic [4:0]  w_idx_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [31:0] r_tt;
    logic [31:0] w_tt_next;
    logic        w_accept;
    logic        w_sample;

    // A start is honoured only outside a sweep. The sample edge is the one
    // that ends the last dwell cycle of the current vector.
    assign w_accept = (r_state != DRIVE) && start;
    assign w_sample = (r_state == DRIVE) && (r_cnt == c_last_cnt);

    // State register and datapath registers; the reset clears everything
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= 5'd0;
            r_cnt   <= 8'd0;
            r_tt    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
            r_tt    <= w_tt_next;
        end
    end

    // Next-state logic and datapath logic. The index returns to 0 only on
    // an accepted start or when the sweep ends. It never wraps.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt;
        w_tt_next    = r_tt;
        case (r_state)
            IDLE, FINISH: begin
                if (start) begin
                    w_state_next = DRIVE;
                    w_idx_next   = 5'd0;
                    w_cnt_next   = 8'd0;
                    w_tt_next    = 32'd0;
                end
            end
            DRIVE: begin
                if (r_cnt == c_last_cnt) begin
                    w_tt_next[r_idx] = f;
                    w_cnt_next       = 8'd0;
                    if (r_idx == c_last_idx) begin
                        w_idx_next   = 5'd0;
                        w_state_next = FINISH;
                    end else begin
                        w_idx_next   = r_idx + 5'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = 5'd0;
                w_cnt_next   = 8'd0;
                w_tt_next    = 32'd0;
            end
        endcase
    end

    // The index is 0 whenever the FSM is outside DRIVE, so the stimulus
    // pins show 00000 at those times.
    assign {a, b, c, d, e} = r_idx;
    assign idx             = r_idx;
    assign tt              = r_tt;
    assign busy            = (r_state == DRIVE);
    assign done            = (r_state == FINISH);

`ifdef TRUTH_TABLE_COMPARE_EN
    logic [5:0] r_mismatch_cnt;

    // At each sample edge, count the responses that differ from the
    // expected table. The count is cleared when a new sweep starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch_cnt <= 6'd0;
        end else if (w_accept) begin
            r_mismatch_cnt <= 6'd0;
        end else if (w_sample && (f != expected[r_idx])) begin
            r_mismatch_cnt <= r_mismatch_cnt + 6'd1;
        end
    end

    assign mismatch_cnt = r_mismatch_cnt;
    assign pass         = done && (r_mismatch_cnt == 6'd0);
`else
    // w_accept and w_sample are used only by the compare logic.
    logic w_unused;
    assign w_unused = w_accept ^ w_sample;
`endif

endmodule
`default_nettype wire
